jtag_master: RTL and testbench



---
 rtl/jtag_master.sv | 211 +++++++++++++++++++++
 tb/tb_jtag_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// jtag_master: upstream JTAG sequencer driving a TAP controller.
//
// Converts a valid/ready request (IR load or DR shift) into TCK_O/TMS_O/TDI_O
// waveforms. It captures TDO_I LSB first and returns the captured bits with a
// one-cycle rsp_valid strobe.
//
// Each JTAG bit period is two TCK cycles:
//   - phase A: TCK_O = 0, and TMS_O/TDI_O change;
//   - phase B: TCK_O = 1, and TDO_I is sampled on the clock edge that ends it.
//
// Ports:
//   TCK, TRST             system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in Run-Test/Idle)
//   req_ir, req_data      1 = IR load of req_data[IR_W-1:0], 0 = DR shift of req_data
//   rsp_valid, rsp_data   one-cycle response strobe, captured TDO bits
//   TCK_O, TMS_O, TDI_O   JTAG pins driven to the TAP
//   TDO_I                 JTAG TDO from the TAP
//
// Optional feature:
//   JTAG_PAUSE_EN  When defined, DR transactions take a detour after Exit1-DR:
//                  Pause-DR for PAUSE_CYCLES periods, then Exit2-DR, then Update-DR.
module jtag_master #(
    parameter int unsigned IR_W         = 4,
    parameter int unsigned DR_W         = 8,
    parameter int unsigned PAUSE_CYCLES = 4
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_ir,
    input  logic [DR_W-1:0] req_data,
    output logic            rsp_valid,
    output logic [DR_W-1:0] rsp_data,
    output logic            TCK_O,
    output logic            TMS_O,
    output logic            TDI_O,
    input  logic            TDO_I
);

    // The counter is shared by every state, so it must reach the longest count in use.
    // Reset needs 6 periods; pause needs PAUSE_CYCLES+1 periods (0..PAUSE_CYCLES).
    localparam int unsigned MaxLen  = (IR_W > DR_W) ? IR_W : DR_W;
    localparam int unsigned MaxCnt0 = (MaxLen > 6) ? MaxLen : 6;
    localparam int unsigned MaxCnt  = (MaxCnt0 > PAUSE_CYCLES) ? MaxCnt0 : PAUSE_CYCLES;
    localparam int unsigned CntW    = $clog2(MaxCnt + 1);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t RstLast   = cnt_t'(5);
    localparam cnt_t HdrIrLast = cnt_t'(3);
    localparam cnt_t HdrDrLast = cnt_t'(2);
    localparam cnt_t IrLast    = cnt_t'(IR_W - 1);
    localparam cnt_t DrLast    = cnt_t'(DR_W - 1);
`ifdef JTAG_PAUSE_EN
    localparam cnt_t PauseLast = cnt_t'(PAUSE_CYCLES);
`endif

    typedef enum logic [2:0] {
        StRstSeq,
        StIdle,
        StHdr,
        StShift,
        StTail
`ifdef JTAG_PAUSE_EN
        , StPause
`endif
    } state_e;

    state_e          state_q, state_d;
    logic            phase_q, phase_d;  // 0 = phase A, 1 = phase B
    cnt_t            cnt_q, cnt_d;
    logic            ir_q, ir_d;
    logic [DR_W-1:0] data_q, data_d;
    logic [DR_W-1:0] rsp_q, rsp_d;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= StRstSeq;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            ir_q    <= 1'b0;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = ~phase_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        data_d    = data_q;
        rsp_d     = rsp_q;
        TMS_O     = 1'b0;
        TDI_O     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            StRstSeq: begin
                // Five periods of TMS=1 reach Test-Logic-Reset; one TMS=0 period reaches Run-Test/Idle.
                TMS_O = (cnt_q != RstLast);
                if (phase_q) begin
                    if (cnt_q == RstLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end

            StIdle: begin
                req_ready = 1'b1;
                phase_d   = 1'b0;
                if (req_valid) begin
                    ir_d    = req_ir;
                    data_d  = req_data;
                    rsp_d   = '0;
                    cnt_d   = '0;
                    state_d = StHdr;
                end
            end

            StHdr: begin
                // IR path: Select-DR, Select-IR, Capture-IR, Shift-IR (TMS 1,1,0,0).
                // DR path: Select-DR, Capture-DR, Shift-DR (TMS 1,0,0).
                TMS_O = ir_q ? (cnt_q < cnt_t'(2)) : (cnt_q == '0);
                if (phase_q) begin
                    if (cnt_q == (ir_q ? HdrIrLast : HdrDrLast)) begin
                        state_d = StShift;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end

            StShift: begin
                TDI_O = data_q[0];
                // The last bit also raises TMS, which moves the TAP to Exit1.
                TMS_O = (cnt_q == (ir_q ? IrLast : DrLast));
                if (phase_q) begin
                    for (int unsigned i = 0; i < DR_W; i++) begin
                        if (cnt_q == cnt_t'(i)) begin
                            rsp_d[i] = TDO_I;
                        end
                    end
                    data_d = data_q >> 1;
                    if (cnt_q == (ir_q ? IrLast : DrLast)) begin
                        cnt_d = '0;
`ifdef JTAG_PAUSE_EN
                        state_d = ir_q ? StTail : StPause;
`else
                        state_d = StTail;
`endif
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end

`ifdef JTAG_PAUSE_EN
            StPause: begin
                // Pause-DR periods use TMS=0; the final period uses TMS=1 to enter Exit2-DR.
                TMS_O = (cnt_q == PauseLast);
                if (phase_q) begin
                    if (cnt_q == PauseLast) begin
                        state_d = StTail;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
`endif

            StTail: begin
                // Update (TMS=1), then Run-Test/Idle (TMS=0).
                TMS_O = (cnt_q == '0);
                if (phase_q) begin
                    if (cnt_q == cnt_t'(1)) begin
                        rsp_valid = 1'b1;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end

            default: begin
                state_d = StRstSeq;
                phase_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign TCK_O    = phase_q;
    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed self-checking bench for jtag_master.
// It contains a small behavioural TAP, with BYPASS (4'hF) and an 8-bit SAMPLE
// register (4'h1) that captures 8'h3C.
// Phase-B samples of TMS/TDI are packed into vectors LSB first, one bit per
// bit period.
module tb_jtag_master;

    localparam int unsigned IR_W = 4;
    localparam int unsigned DR_W = 8;

`ifdef JTAG_PAUSE_EN
    localparam int          DR_LAT  = 36;
    localparam int          DR_NPER = 18;
    localparam logic [31:0] DR_TMS  = 32'h0001_8401;
`else
    localparam int          DR_LAT  = 26;
    localparam int          DR_NPER = 13;
    localparam logic [31:0] DR_TMS  = 32'h0000_0C01;
`endif

    logic            TCK = 1'b0;
    logic            TRST;
    logic            req_valid;
    logic            req_ready;
    logic            req_ir;
    logic [DR_W-1:0] req_data;
    logic            rsp_valid;
    logic [DR_W-1:0] rsp_data;
    logic            TCK_O;
    logic            TMS_O;
    logic            TDI_O;
    logic            TDO_I;

    logic use_tap   = 1'b0;
    logic tdo_const = 1'b0;
    logic tap_tdo   = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 TCK = ~TCK;

    assign TDO_I = use_tap ? tap_tdo : tdo_const;

    jtag_master #(
        .IR_W        (IR_W),
        .DR_W        (DR_W),
        .PAUSE_CYCLES(4)
    ) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_ir   (req_ir),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .TCK_O    (TCK_O),
        .TMS_O    (TMS_O),
        .TDI_O    (TDI_O),
        .TDO_I    (TDO_I)
    );

    // ---------------- behavioural TAP ----------------
    typedef enum logic [3:0] {
        TTlr, TRti, TSelDr, TCapDr, TShDr, TEx1Dr, TPDr, TEx2Dr, TUpDr,
        TSelIr, TCapIr, TShIr, TEx1Ir, TPIr, TEx2Ir, TUpIr
    } tap_e;

    tap_e       tap_st  = TTlr;
    logic [3:0] ir_sr   = 4'h0;
    logic [3:0] ir_reg  = 4'hF;
    logic       byp     = 1'b0;
    logic [7:0] bsr_sr  = 8'h00;
    logic [7:0] bsr_upd = 8'h00;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            TTlr:    return tms ? TTlr   : TRti;
            TRti:    return tms ? TSelDr : TRti;
            TSelDr:  return tms ? TSelIr : TCapDr;
            TCapDr:  return tms ? TEx1Dr : TShDr;
            TShDr:   return tms ? TEx1Dr : TShDr;
            TEx1Dr:  return tms ? TUpDr  : TPDr;
            TPDr:    return tms ? TEx2Dr : TPDr;
            TEx2Dr:  return tms ? TUpDr  : TShDr;
            TUpDr:   return tms ? TSelDr : TRti;
            TSelIr:  return tms ? TTlr   : TCapIr;
            TCapIr:  return tms ? TEx1Ir : TShIr;
            TShIr:   return tms ? TEx1Ir : TShIr;
            TEx1Ir:  return tms ? TUpIr  : TPIr;
            TPIr:    return tms ? TEx2Ir : TPIr;
            TEx2Ir:  return tms ? TUpIr  : TShIr;
            TUpIr:   return tms ? TSelDr : TRti;
            default: return TTlr;
        endcase
    endfunction

    always @(posedge TCK_O) begin
        case (tap_st)
            TTlr:    ir_reg <= 4'hF;
            TCapIr:  ir_sr <= 4'b0001;
            TShIr:   ir_sr <= {TDI_O, ir_sr[3:1]};
            TUpIr:   ir_reg <= ir_sr;
            TCapDr:  if (ir_reg == 4'h1) bsr_sr <= 8'h3C; else byp <= 1'b0;
            TShDr:   if (ir_reg == 4'h1) bsr_sr <= {TDI_O, bsr_sr[7:1]}; else byp <= TDI_O;
            TUpDr:   if (ir_reg == 4'h1) bsr_upd <= bsr_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, TMS_O);
    end

    always @(negedge TCK_O) begin
        if (tap_st == TShIr)      tap_tdo <= ir_sr[0];
        else if (tap_st == TShDr) tap_tdo <= (ir_reg == 4'h1) ? bsr_sr[0] : byp;
        else                      tap_tdo <= 1'b0;
    end

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tck"}, 32'(TCK_O), 32'd0);
        check_eq({tag, "_tms"}, 32'(TMS_O), 32'd1);
        check_eq({tag, "_tdi"}, 32'(TDI_O), 32'd0);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rspd"}, 32'(rsp_data), 32'd0);
    endtask

    // Call this at the negedge of the first cycle after the reset edge.
    task automatic check_rst_seq(input string tag);
        logic [5:0] tms;
        int         rises;
        int         rdy;
        int         rv;
        logic       prev;
        tms = '0;
        rises = 0;
        rdy = 0;
        rv = 0;
        prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge TCK);
            if (TCK_O && !prev) rises++;
            if (TCK_O) tms = {TMS_O, tms[5:1]};
            prev = TCK_O;
            if (req_ready) rdy++;
            if (rsp_valid) rv++;
        end
        @(negedge TCK);
        check_eq({tag, "_tms"}, 32'(tms), 32'h1F);
        check_eq({tag, "_tck_rises"}, 32'(rises), 32'd6);
        check_eq({tag, "_ready_early"}, 32'(rdy), 32'd0);
        check_eq({tag, "_rspv"}, 32'(rv), 32'd0);
        check_eq({tag, "_ready13"}, 32'(req_ready), 32'd1);
    endtask

    // Call this at the negedge of the accept cycle, with the request already on the pins.
    task automatic wait_rsp(input bit keep_valid, output logic [7:0] rsp, output int lat,
                            output logic [31:0] tms, output logic [31:0] tdi, output int nper);
        rsp = '0;
        lat = -1;
        tms = '0;
        tdi = '0;
        nper = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge TCK);
            if (k == 1) begin
                if (!keep_valid) req_valid = 1'b0;
                req_data = ~req_data;
            end
            // A request raised while the block is busy must be ignored.
            if (!keep_valid && k == 4) req_valid = 1'b1;
            if (!keep_valid && k == 5) req_valid = 1'b0;
            if (TCK_O && nper < 32) begin
                tms[nper[4:0]] = TMS_O;
                tdi[nper[4:0]] = TDI_O;
                nper++;
            end
            if (rsp_valid) begin
                lat = k;
                rsp = rsp_data;
                break;
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge TCK);
            n++;
        end
        check_eq("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_txn(input logic ir, input logic [7:0] data, output logic [7:0] rsp,
                          output int lat, output logic [31:0] tms, output logic [31:0] tdi,
                          output int nper);
        wait_ready();
        req_valid = 1'b1;
        req_ir    = ir;
        req_data  = data;
        wait_rsp(1'b0, rsp, lat, tms, tdi, nper);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rsp;
        logic [7:0]  rsp2;
        int          lat;
        int          lat2;
        int          nper;
        logic [31:0] tms;
        logic [31:0] tdi;

        TRST      = 1'b1;
        req_valid = 1'b0;
        req_ir    = 1'b0;
        req_data  = '0;

        // 1. Reset sequence
        @(negedge TCK);
        check_reset_vals("rst");
        TRST = 1'b0;
        check_rst_seq("rst");

        // 2. IR load 4'hF, TDO tied 1, with the unused upper bits set
        use_tap   = 1'b0;
        tdo_const = 1'b1;
        do_txn(1'b1, 8'hFF, rsp, lat, tms, tdi, nper);
        check_eq("ir_lat", 32'(lat), 32'd20);
        check_eq("ir_nper", 32'(nper), 32'd10);
        check_eq("ir_tms", tms, 32'h183);
        check_eq("ir_tdi", tdi, 32'h0F0);
        check_eq("ir_rsp", 32'(rsp), 32'h0F);

        // DR shift with TDO tied 1
        do_txn(1'b0, 8'hA5, rsp, lat, tms, tdi, nper);
        check_eq("dr_lat", 32'(lat), 32'(DR_LAT));
        check_eq("dr_nper", 32'(nper), 32'(DR_NPER));
        check_eq("dr_tms", tms, DR_TMS);
        check_eq("dr_tdi", tdi, 32'h528);
        check_eq("dr_rsp", 32'(rsp), 32'hFF);

        // 3. Against the TAP model: BYPASS, then SAMPLE
        use_tap = 1'b1;
        do_txn(1'b1, 8'h0F, rsp, lat, tms, tdi, nper);
        check_eq("byp_ir_rsp", 32'(rsp), 32'h01);
        do_txn(1'b0, 8'h81, rsp, lat, tms, tdi, nper);
        check_eq("byp_dr_rsp", 32'(rsp), 32'h02);
        check_eq("byp_dr_lat", 32'(lat), 32'(DR_LAT));
        do_txn(1'b1, 8'h01, rsp, lat, tms, tdi, nper);
        check_eq("smp_ir_rsp", 32'(rsp), 32'h01);
        check_eq("smp_ir_tdi", tdi, 32'h010);
        do_txn(1'b0, 8'hA5, rsp, lat, tms, tdi, nper);
        check_eq("smp_dr_rsp", 32'(rsp), 32'h3C);
        check_eq("smp_upd", 32'(bsr_upd), 32'hA5);
        @(negedge TCK);
        check_eq("smp_rspv_pulse", 32'(rsp_valid), 32'd0);
        check_eq("smp_ready_after", 32'(req_ready), 32'd1);
        check_eq("smp_tap_rti", 32'(tap_st), 32'(TRti));
        @(negedge TCK);
        check_eq("stray_req_ignored", 32'(req_ready), 32'd1);

        // 4. Back-to-back DR shifts through BYPASS, with req_valid held high
        do_txn(1'b1, 8'h0F, rsp, lat, tms, tdi, nper);
        wait_ready();
        req_valid = 1'b1;
        req_ir    = 1'b0;
        req_data  = 8'h33;
        wait_rsp(1'b1, rsp, lat, tms, tdi, nper);
        req_data = 8'hC9;
        @(negedge TCK);
        check_eq("b2b_ready", 32'(req_ready), 32'd1);
        wait_rsp(1'b0, rsp2, lat2, tms, tdi, nper);
        check_eq("b2b_lat1", 32'(lat), 32'(DR_LAT));
        check_eq("b2b_rsp1", 32'(rsp), 32'h66);
        check_eq("b2b_lat2", 32'(lat2), 32'(DR_LAT));
        check_eq("b2b_rsp2", 32'(rsp2), 32'h92);

        // 5. Reset during DR shift bit 3 (cycle 13 after accept, phase A)
        wait_ready();
        req_valid = 1'b1;
        req_ir    = 1'b0;
        req_data  = 8'hFF;
        lat = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge TCK);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid) lat++;
        end
        check_eq("mid_rsp_partial", 32'(rsp_data), 32'h06);
        check_eq("mid_no_rspv", 32'(lat), 32'd0);
        TRST = 1'b1;
        @(negedge TCK);
        check_reset_vals("mid");
        TRST = 1'b0;
        check_rst_seq("mid_rst");
        do_txn(1'b1, 8'h01, rsp, lat, tms, tdi, nper);
        check_eq("post_ir_lat", 32'(lat), 32'd20);
        check_eq("post_ir_rsp", 32'(rsp), 32'h01);
        check_eq("post_ir_reg", 32'(ir_reg), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
